// File: rtl/dmem_init_loader.sv
// Copies a 16-byte data image into data memory, optionally reads it back
// to verify, and holds the CPU in reset until the image is in place.
//
// Ports:
//   Clock, Reset_N       clock, async active-low reset
//   init_image[127:0]    source image, byte k at [8k+7:8k]
//   load_req             single-cycle start / reload / retry request
//   dm_addr, dm_wdata,
//   dm_we                data-memory write port (address shared with read)
//   dm_rdata             data-memory read data, one cycle after dm_addr
//   cpu_hold             CPU reset hold
//   load_done            image loaded (and verified when enabled)
//   load_error           read-back mismatch seen
//   err_addr             address of the first mismatching byte
module dmem_init_loader #(
  parameter logic VERIFY_EN  = 1'b1,
  parameter logic AUTO_START = 1'b1
) (
  input  logic         Clock,
  input  logic         Reset_N,
  input  logic [127:0] init_image,
  input  logic         load_req,
  output logic [3:0]   dm_addr,
  output logic [7:0]   dm_wdata,
  output logic         dm_we,
  input  logic [7:0]   dm_rdata,
  output logic         cpu_hold,
  output logic         load_done,
  output logic         load_error,
  output logic [3:0]   err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic        cmp_v_q, cmp_v_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [3:0]  err_q, err_d;
  logic [7:0]  snap_q [16];
  logic        start;
  logic [3:0]  k_inc;
  logic [3:0]  cmp_idx;

  assign k_inc   = k_q + 4'd1;
  // In VERIFY, k is the address on the bus; the byte arriving on
  // dm_rdata belongs to the address presented one cycle earlier.
  assign cmp_idx = k_q - 4'd1;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cmp_v_d = cmp_v_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    hold_d  = hold_q;
    done_d  = done_q;
    error_d = error_q;
    err_d   = err_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (AUTO_START || load_req) start = 1'b1;
      end
      S_LOAD: begin
        if (k_inc == 4'd0) begin
          k_d     = 4'd0;
          addr_d  = 4'd0;
          wdata_d = 8'd0;
          we_d    = 1'b0;
          cmp_v_d = 1'b0;
          if (VERIFY_EN) begin
            state_d = S_VERIFY;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end
        end else begin
          k_d     = k_inc;
          addr_d  = k_inc;
          wdata_d = snap_q[k_inc];
        end
      end
      S_VERIFY: begin
        k_d     = k_inc;
        addr_d  = k_inc;
        cmp_v_d = 1'b1;
        if (cmp_v_q) begin
          if (dm_rdata != snap_q[cmp_idx]) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            err_d   = cmp_idx;
            k_d     = 4'd0;
            addr_d  = 4'd0;
          end else if (k_q == 4'd0) begin
            // k wrapped: byte 15 has just been compared
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
            addr_d  = 4'd0;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (load_req) start = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d = S_LOAD;
      k_d     = 4'd0;
      cmp_v_d = 1'b0;
      addr_d  = 4'd0;
      wdata_d = init_image[7:0];
      we_d    = 1'b1;
      hold_d  = 1'b1;
      done_d  = 1'b0;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= S_IDLE;
      k_q     <= 4'd0;
      cmp_v_q <= 1'b0;
      addr_q  <= 4'd0;
      wdata_q <= 8'd0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      err_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cmp_v_q <= cmp_v_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
      err_q   <= err_d;
    end
  end

  // Image snapshot: only written on load start, so it needs no reset.
  always_ff @(posedge Clock) begin
    if (start) begin
      for (int i = 0; i < 16; i++) begin
        snap_q[i] <= init_image[8*i +: 8];
      end
    end
  end

  assign dm_addr    = addr_q;
  assign dm_wdata   = wdata_q;
  assign dm_we      = we_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_error = error_q;
  assign err_addr   = err_q;

endmodule

// File: tb/tb_dmem_init_loader.sv
// Directed bench for dmem_init_loader: default config plus a
// VERIFY_EN=0 / AUTO_START=0 instance, each with its own memory model.
module tb_dmem_init_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] init_image;
  logic         load_req = 1'b0;
  logic         load_req2 = 1'b0;
  logic         stuck = 1'b0;

  logic [3:0] dm_addr, err_addr, dm_addr2, err_addr2;
  logic [7:0] dm_wdata, dm_rdata, dm_wdata2, dm_rdata2;
  logic       dm_we, cpu_hold, load_done, load_error;
  logic       dm_we2, cpu_hold2, load_done2, load_error2;

  logic [7:0]  mem  [16];
  logic [7:0]  mem2 [16];
  logic [11:0] wlog [$];
  logic [11:0] wlog2 [$];
  logic [7:0]  img  [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_init_loader dut (
    .Clock(clk), .Reset_N(rst_n), .init_image(init_image),
    .load_req(load_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_we(dm_we), .dm_rdata(dm_rdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error),
    .err_addr(err_addr)
  );

  dmem_init_loader #(.VERIFY_EN(1'b0), .AUTO_START(1'b0)) dut2 (
    .Clock(clk), .Reset_N(rst_n), .init_image(init_image),
    .load_req(load_req2), .dm_addr(dm_addr2), .dm_wdata(dm_wdata2),
    .dm_we(dm_we2), .dm_rdata(dm_rdata2), .cpu_hold(cpu_hold2),
    .load_done(load_done2), .load_error(load_error2),
    .err_addr(err_addr2)
  );

  // Synchronous-read memories; the first has an optional stuck-at-0
  // on bit 3 of address 9 on the read side.
  always @(posedge clk) begin
    if (dm_we) begin
      mem[dm_addr] <= dm_wdata;
      wlog.push_back({dm_addr, dm_wdata});
    end
    if (stuck && dm_addr == 4'd9) dm_rdata <= mem[dm_addr] & 8'hF7;
    else dm_rdata <= mem[dm_addr];
    if (dm_we2) begin
      mem2[dm_addr2] <= dm_wdata2;
      wlog2.push_back({dm_addr2, dm_wdata2});
    end
    dm_rdata2 <= mem2[dm_addr2];
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req;
    load_req = 1'b1;
    cyc(1);
    load_req = 1'b0;
  endtask

  task automatic test_reset;
    cyc(3);
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", dm_we); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_hold got %b exp 1", cpu_hold); end
    checks++; if ({load_done, load_error} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {load_done, load_error}); end
    checks++; if ({dm_addr, dm_wdata, err_addr} !== 16'h0) begin errors++; $display("FAIL rst_regs got %h exp 0000", {dm_addr, dm_wdata, err_addr}); end
  endtask

  task automatic test_auto_load;
    wlog.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    checks++; if ({dm_we, dm_addr, cpu_hold} !== 6'b1_0000_1) begin errors++; $display("FAIL auto_first got %b exp 100001", {dm_we, dm_addr, cpu_hold}); end
    cyc(32);
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL auto_early got %b exp 0", load_done); end
    cyc(1);
    checks++; if ({load_done, cpu_hold} !== 2'b10) begin errors++; $display("FAIL auto_done got %b exp 10", {load_done, cpu_hold}); end
    checks++; if (wlog.size() != 16) begin errors++; $display("FAIL auto_nwr got %0d exp 16", wlog.size()); end
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i] !== {i[3:0], img[i]}) begin
        errors++; $display("FAIL auto_wr%0d got %h exp %h", i, wlog[i], {i[3:0], img[i]});
      end
    end
  endtask

  task automatic test_verify_error;
    stuck = 1'b1;
    pulse_req();
    checks++; if ({cpu_hold, load_done} !== 2'b10) begin errors++; $display("FAIL err_start got %b exp 10", {cpu_hold, load_done}); end
    cyc(26);
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", load_error); end
    cyc(1);
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL err_flag got %b exp 1", load_error); end
    checks++; if (err_addr !== 4'd9) begin errors++; $display("FAIL err_addr got %0d exp 9", err_addr); end
    cyc(5);
    checks++; if ({cpu_hold, load_done, load_error, dm_we} !== 4'b1010) begin errors++; $display("FAIL err_hold got %b exp 1010", {cpu_hold, load_done, load_error, dm_we}); end
    checks++; if (err_addr !== 4'd9) begin errors++; $display("FAIL err_keep got %0d exp 9", err_addr); end
  endtask

  task automatic test_retry;
    stuck = 1'b0;
    pulse_req();
    checks++; if ({load_error, dm_we} !== 2'b01) begin errors++; $display("FAIL retry_start got %b exp 01", {load_error, dm_we}); end
    cyc(33);
    checks++; if ({load_done, load_error, cpu_hold} !== 3'b100) begin errors++; $display("FAIL retry_done got %b exp 100", {load_done, load_error, cpu_hold}); end
  endtask

  task automatic test_reload;
    init_image[8*4 +: 8] = 8'h20;
    wlog.delete();
    pulse_req();
    checks++; if ({cpu_hold, load_done} !== 2'b10) begin errors++; $display("FAIL reload_hold got %b exp 10", {cpu_hold, load_done}); end
    cyc(32);
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reload_early got %b exp 0", load_done); end
    cyc(1);
    checks++; if ({load_done, cpu_hold, load_error} !== 3'b100) begin errors++; $display("FAIL reload_done got %b exp 100", {load_done, cpu_hold, load_error}); end
    checks++; if (mem[4] !== 8'h20) begin errors++; $display("FAIL reload_mem4 got %h exp 20", mem[4]); end
    checks++; if (wlog.size() < 5 || wlog[4] !== 12'h420) begin errors++; $display("FAIL reload_wr4 got %0d entries, exp entry 4 = 420", wlog.size()); end
  endtask

  task automatic test_ignore_and_snapshot;
    wlog.delete();
    pulse_req();
    cyc(3);
    checks++; if (dm_addr !== 4'd3) begin errors++; $display("FAIL snap_k3 got %0d exp 3", dm_addr); end
    init_image[8*10 +: 8] = 8'h77;
    cyc(4);
    checks++; if (dm_addr !== 4'd7) begin errors++; $display("FAIL ign_k7 got %0d exp 7", dm_addr); end
    pulse_req();
    checks++; if ({dm_we, dm_addr} !== 5'b1_1000) begin errors++; $display("FAIL ign_k8 got %b exp 11000", {dm_we, dm_addr}); end
    cyc(24);
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL ign_early got %b exp 0", load_done); end
    cyc(1);
    checks++; if ({load_done, load_error} !== 2'b10) begin errors++; $display("FAIL ign_done got %b exp 10", {load_done, load_error}); end
    checks++; if (mem[10] !== 8'h40) begin errors++; $display("FAIL snap_mem10 got %h exp 40", mem[10]); end
    checks++; if (wlog.size() != 16) begin errors++; $display("FAIL ign_nwr got %0d exp 16", wlog.size()); end
    init_image[8*10 +: 8] = img[10];
  endtask

  task automatic test_reset_mid_load;
    pulse_req();
    cyc(10);
    checks++; if ({dm_we, dm_addr} !== 5'b1_1010) begin errors++; $display("FAIL mid_k10 got %b exp 11010", {dm_we, dm_addr}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({dm_we, cpu_hold, load_done, load_error} !== 4'b0100) begin errors++; $display("FAIL mid_async got %b exp 0100", {dm_we, cpu_hold, load_done, load_error}); end
    checks++; if ({dm_addr, dm_wdata} !== 12'h0) begin errors++; $display("FAIL mid_regs got %h exp 000", {dm_addr, dm_wdata}); end
    cyc(2);
    wlog.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    checks++; if ({dm_we, dm_addr} !== 5'b1_0000) begin errors++; $display("FAIL mid_restart got %b exp 10000", {dm_we, dm_addr}); end
    cyc(33);
    checks++; if ({load_done, cpu_hold} !== 2'b10) begin errors++; $display("FAIL mid_done got %b exp 10", {load_done, cpu_hold}); end
    checks++; if (wlog.size() != 16 || wlog[0] !== {4'd0, img[0]}) begin errors++; $display("FAIL mid_wr0 got %0d entries exp 16 from addr 0", wlog.size()); end
  endtask

  task automatic test_noverify_manual;
    checks++; if ({cpu_hold2, dm_we2, load_done2} !== 3'b100) begin errors++; $display("FAIL nv_idle got %b exp 100", {cpu_hold2, dm_we2, load_done2}); end
    wlog2.delete();
    load_req2 = 1'b1;
    cyc(1);
    load_req2 = 1'b0;
    checks++; if ({dm_we2, dm_addr2} !== 5'b1_0000) begin errors++; $display("FAIL nv_first got %b exp 10000", {dm_we2, dm_addr2}); end
    cyc(15);
    checks++; if ({load_done2, dm_we2, dm_addr2} !== 6'b0_1_1111) begin errors++; $display("FAIL nv_last got %b exp 011111", {load_done2, dm_we2, dm_addr2}); end
    cyc(1);
    checks++; if ({load_done2, cpu_hold2, load_error2} !== 3'b100) begin errors++; $display("FAIL nv_done got %b exp 100", {load_done2, cpu_hold2, load_error2}); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dm_we2 !== 1'b0) begin errors++; $display("FAIL nv_we%0d got %b exp 0", i, dm_we2); end
      cyc(1);
    end
    checks++; if (wlog2.size() != 16) begin errors++; $display("FAIL nv_nwr got %0d exp 16", wlog2.size()); end
    checks++; if ({mem2[7], mem2[15]} !== {img[7], img[15]}) begin errors++; $display("FAIL nv_mem got %h exp %h", {mem2[7], mem2[15]}, {img[7], img[15]}); end
  endtask

  initial begin
    img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h04,
            8'h40, 8'h08, 8'h40, 8'h01, 8'h01, 8'h00, 8'h00, 8'h03};
    for (int i = 0; i < 16; i++) begin
      init_image[8*i +: 8] = img[i];
      mem[i] = 8'h00;
      mem2[i] = 8'h00;
    end
    test_reset();
    test_auto_load();
    test_verify_error();
    test_retry();
    test_reload();
    test_ignore_and_snapshot();
    test_reset_mid_load();
    test_noverify_manual();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
